// File: rtl/enc_bundler.sv
// Hypervector bundler: sums bound feature HVs per dimension over NUM_PASSES beats,
// thresholds the per-dimension counts into a query HV and holds it until accepted.
module enc_bundler #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURES_PER_CC = 8,
    parameter int NUM_PASSES      = 4,
    parameter int THRESHOLD       = 3,
    parameter int CNT_W           = $clog2(FEATURES_PER_CC*NUM_PASSES+1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              feat_valid,
    input  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1],
    input  logic              query_ready,
    output logic [HV_DIM-1:0] query_hv,
    output logic              query_valid,
    output logic              busy
);

    localparam int PASS_W = $clog2(NUM_PASSES+1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES-1);
    localparam logic [CNT_W-1:0]  THR       = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, HOLD} state_t;

    state_t            state_q;
    logic [PASS_W-1:0] pass_q;
    logic [CNT_W-1:0]  cnt_q [HV_DIM];
    logic [CNT_W-1:0]  pop_d [HV_DIM];
    logic [HV_DIM-1:0] query_hv_q;
    logic              query_valid_q;
    logic              busy_q;

    // Column popcount across the feature lanes, one adder tree per dimension.
    always_comb begin
        for (int d = 0; d < HV_DIM; d++) begin
            pop_d[d] = '0;
            for (int f = 0; f < FEATURES_PER_CC; f++) begin
                pop_d[d] = pop_d[d] + CNT_W'(shifted_hv[f][d]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q       <= IDLE;
            pass_q        <= '0;
            query_hv_q    <= '0;
            query_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int d = 0; d < HV_DIM; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_encoding) begin
                        for (int d = 0; d < HV_DIM; d++) begin
                            cnt_q[d] <= '0;
                        end
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (feat_valid) begin
                        for (int d = 0; d < HV_DIM; d++) begin
                            cnt_q[d] <= cnt_q[d] + pop_d[d];
                        end
                        pass_q <= pass_q + 1'b1;
                        if (pass_q == LAST_PASS) begin
                            state_q <= THRESH;
                        end
                    end
                end
                THRESH: begin
                    for (int d = 0; d < HV_DIM; d++) begin
                        query_hv_q[d] <= (cnt_q[d] >= THR);
                    end
                    query_valid_q <= 1'b1;
                    state_q       <= HOLD;
                end
                HOLD: begin
                    // query_hv is left untouched so it stays readable in IDLE.
                    if (query_ready) begin
                        query_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign query_hv    = query_hv_q;
    assign query_valid = query_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_enc_bundler.sv
// Bench for enc_bundler: directed vector table, hold/reset sequences and
// randomized samples checked against a per-dimension counting model.
module tb_enc_bundler;

    localparam int HV = 8;
    localparam int F  = 4;
    localparam int P  = 2;
    localparam int TH = 3;

    typedef logic [P-1:0][F-1:0][HV-1:0] sample_t;
    typedef struct {
        string             name;
        sample_t           s;
        int                gap;
        logic [HV-1:0]     exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start_encoding;
    logic          feat_valid;
    logic [HV-1:0] shifted_hv [0:F-1];
    logic          query_ready;
    logic [HV-1:0] query_hv;
    logic          query_valid;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc_bundler #(
        .HV_DIM(HV), .FEATURES_PER_CC(F), .NUM_PASSES(P), .THRESHOLD(TH)
    ) u_dut (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding),
        .feat_valid(feat_valid), .shifted_hv(shifted_hv),
        .query_ready(query_ready), .query_hv(query_hv),
        .query_valid(query_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Count set bits per dimension over every lane of every beat, then threshold.
    function automatic logic [HV-1:0] model(input sample_t s);
        logic [HV-1:0] r;
        int c;
        for (int d = 0; d < HV; d++) begin
            c = 0;
            for (int p = 0; p < P; p++)
                for (int f = 0; f < F; f++)
                    c += int'(s[p][f][d]);
            r[d] = (c >= TH);
        end
        return r;
    endfunction

    task automatic drive_lanes(input logic [F-1:0][HV-1:0] b);
        for (int f = 0; f < F; f++) shifted_hv[f] = b[f];
    endtask

    // Runs one sample; gap bubbles (with junk data) precede the final beat.
    task automatic run_sample(input string name, input sample_t s, input int gap,
                              input logic [HV-1:0] exp, input bit ack);
        int edges;
        start_encoding = 1'b1;
        @(posedge clk); #1;
        start_encoding = 1'b0;
        check($sformatf("%s busy_accum", name), 32'(busy), 32'd1);
        for (int p = 0; p < P; p++) begin
            if (p == P-1) begin
                for (int g = 0; g < gap; g++) begin
                    feat_valid = 1'b0;
                    drive_lanes({F{8'(($urandom))}});
                    @(posedge clk); #1;
                end
            end
            drive_lanes(s[p]);
            feat_valid = 1'b1;
            @(posedge clk); #1;
            feat_valid = 1'b0;
        end
        edges = 1;
        while (!query_valid && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("%s latency", name), 32'(edges), 32'd2);
        check($sformatf("%s query_hv", name), 32'(query_hv), 32'(exp));
        if (ack) begin
            query_ready = 1'b1;
            @(posedge clk); #1;
            query_ready = 1'b0;
            check($sformatf("%s valid_clear", name), 32'(query_valid), 32'd0);
            check($sformatf("%s busy_idle", name), 32'(busy), 32'd0);
            check($sformatf("%s hv_retained", name), 32'(query_hv), 32'(exp));
        end
    endtask

    vec_t vecs[5];

    initial begin
        sample_t s;
        logic [HV-1:0] exp;

        nrst = 1'b1; start_encoding = 1'b0; feat_valid = 1'b0; query_ready = 1'b0;
        drive_lanes('0);
        repeat (2) @(posedge clk);
        #1;
        check("reset query_hv", 32'(query_hv), 32'd0);
        check("reset query_valid", 32'(query_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        nrst = 1'b0;

        s = '0; for (int p = 0; p < P; p++) for (int f = 0; f < F; f++) s[p][f] = 8'hFF;
        vecs[0] = '{"all_ff", s, 0, 8'hFF};
        s = '0; s[0][0] = 8'h01; s[1][0] = 8'h01; s[1][1] = 8'h01; s[1][2] = 8'h80;
        vecs[1] = '{"sparse", s, 0, 8'h01};
        vecs[2] = '{"sparse_gap3", s, 3, 8'h01};
        s = '0; s[0][0] = 8'h06; s[0][1] = 8'h04; s[1][0] = 8'h04; s[1][1] = 8'h02;
        vecs[3] = '{"thr_boundary", s, 1, 8'h04};
        vecs[4] = '{"all_zero", sample_t'('0), 2, 8'h00};

        foreach (vecs[i])
            run_sample(vecs[i].name, vecs[i].s, vecs[i].gap, vecs[i].exp, 1'b1);

        // Stall in HOLD with a stray start pulse; outputs must not move.
        run_sample("hold", vecs[0].s, 0, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start_encoding = (i == 2);
            @(posedge clk); #1;
            check($sformatf("hold%0d valid", i), 32'(query_valid), 32'd1);
            check($sformatf("hold%0d hv", i), 32'(query_hv), 32'hFF);
            check($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
        end
        start_encoding = 1'b0;
        query_ready = 1'b1;
        @(posedge clk); #1;
        query_ready = 1'b0;
        check("hold release valid", 32'(query_valid), 32'd0);
        check("hold release busy", 32'(busy), 32'd0);

        // Reset mid-sample after one all-ones beat, then a clean sparse sample.
        start_encoding = 1'b1;
        @(posedge clk); #1;
        start_encoding = 1'b0;
        drive_lanes(vecs[0].s[0]);
        feat_valid = 1'b1;
        @(posedge clk); #1;
        feat_valid = 1'b0;
        nrst = 1'b1;
        @(posedge clk); #1;
        check("midreset query_hv", 32'(query_hv), 32'd0);
        check("midreset query_valid", 32'(query_valid), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        nrst = 1'b0;
        run_sample("post_reset", vecs[1].s, 0, 8'h01, 1'b1);

        for (int n = 0; n < 30; n++) begin
            for (int p = 0; p < P; p++)
                for (int f = 0; f < F; f++)
                    s[p][f] = 8'($urandom) & 8'($urandom);
            exp = model(s);
            run_sample($sformatf("rand%0d", n), s, int'($urandom_range(0, 3)), exp, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
